// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; strobes each good word and pulses parity/framing errors.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    input  logic                 BIST_Mode,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Parity_Err,
    output logic                 Framing_Err,
    output logic                 Rx_Busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        timer, timer_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bad, par_bad_n;
    logic                 rdy_n, pe_n, fe_n;
    logic                 rx_m, rx_s, rx_p;
    logic                 mid, last;

    assign mid  = timer == TW'(CLKS_PER_BIT / 2 - 1);
    assign last = timer == TW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_n   = state;
        timer_n   = timer + 1'b1;
        idx_n     = idx;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        rdy_n     = 1'b0;
        pe_n      = 1'b0;
        fe_n      = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (rx_p && !rx_s) begin
                    state_n   = START;
                    par_bad_n = 1'b0;
                end
            end
            START: if (mid) begin
                timer_n = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (last) begin
                timer_n = '0;
                shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                idx_n   = idx + 1'b1;
                if (idx == IW'(DATA_BITS - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (last) begin
                timer_n   = '0;
                par_bad_n = rx_s != ((^shreg) ^ (PARITY_ODD != 0));
                state_n   = STOP;
            end
            // Sampling at mid stop bit frees the receiver for an immediate next start edge.
            STOP: if (last) begin
                timer_n = '0;
                rdy_n   = rx_s && !par_bad;
                pe_n    = rx_s && par_bad;
                fe_n    = !rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                timer_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (BIST_Mode) begin
            state_n = IDLE;
            timer_n = '0;
            rdy_n   = 1'b0;
            pe_n    = 1'b0;
            fe_n    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_m, rx_s, rx_p} <= 3'b111;
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            Rx_Data     <= '0;
            Data_Rdy    <= 1'b0;
            Parity_Err  <= 1'b0;
            Framing_Err <= 1'b0;
            Rx_Busy     <= 1'b0;
        end else begin
            {rx_m, rx_s, rx_p} <= {Rx, rx_m, rx_s};
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            par_bad     <= par_bad_n;
            Rx_Data     <= rdy_n ? shreg : Rx_Data;
            Data_Rdy    <= rdy_n;
            Parity_Err  <= pe_n;
            Framing_Err <= fe_n;
            Rx_Busy     <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into an 8N1 receiver and an 8E1 receiver at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0, rst = 1'b1, rx0 = 1'b1, rx1 = 1'b1, bist = 1'b0;
    logic [7:0] data0, data1;
    logic       rdy0, perr0, ferr0, busy0, rdy1, perr1, ferr1, busy1;
    int         checks = 0, errors = 0, cyc = 0, rdy_cyc = 0, t0 = 0;
    int         n_rdy0 = 0, n_pe0 = 0, n_fe0 = 0, n_rdy1 = 0, n_pe1 = 0, n_fe1 = 0, n_multi = 0;
    logic [7:0] w0[$];

    uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .Rx(rx0), .BIST_Mode(bist), .Rx_Data(data0),
        .Data_Rdy(rdy0), .Parity_Err(perr0), .Framing_Err(ferr0), .Rx_Busy(busy0));

    uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .Rx(rx1), .BIST_Mode(bist), .Rx_Data(data1),
        .Data_Rdy(rdy1), .Parity_Err(perr1), .Framing_Err(ferr1), .Rx_Busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy0) begin
            n_rdy0 <= n_rdy0 + 1;
            w0.push_back(data0);
            rdy_cyc <= cyc;
        end
        if (perr0) n_pe0 <= n_pe0 + 1;
        if (ferr0) n_fe0 <= n_fe0 + 1;
        if (rdy1) n_rdy1 <= n_rdy1 + 1;
        if (perr1) n_pe1 <= n_pe1 + 1;
        if (ferr1) n_fe1 <= n_fe1 + 1;
        if (int'(rdy0) + int'(perr0) + int'(ferr0) > 1 || int'(rdy1) + int'(perr1) + int'(ferr1) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit0(input logic v);
        rx0 = v;
        hold(CPB);
    endtask

    task automatic bit1(input logic v);
        rx1 = v;
        hold(CPB);
    endtask

    task automatic frame0(input logic [7:0] d, input logic stop);
        bit0(1'b0);
        for (int i = 0; i < 8; i++) bit0(d[i]);
        bit0(stop);
    endtask

    task automatic frame1(input logic [7:0] d, input logic par);
        bit1(1'b0);
        for (int i = 0; i < 8; i++) bit1(d[i]);
        bit1(par);
        bit1(1'b1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] d;
        hold(3);
        chk("reset_u0", {data0, rdy0, perr0, ferr0, busy0}, 0);
        chk("reset_u1", {data1, rdy1, perr1, ferr1, busy1}, 0);
        rst = 1'b0;
        hold(5);

        t0 = cyc;
        frame0(8'hA5, 1'b1);
        hold(20);
        chk("good_cnt", n_rdy0, 1);
        chk("good_word", w0[0], 8'hA5);
        chk("good_rxdata", data0, 8'hA5);
        chk("good_errs", n_pe0 + n_fe0, 0);
        chk("good_busy", busy0, 0);
        chk("good_latency", (rdy_cyc - t0 >= 155) && (rdy_cyc - t0 <= 157), 1);

        frame0(8'h00, 1'b1);
        frame0(8'hFF, 1'b1);
        frame0(8'h3C, 1'b1);
        hold(20);
        chk("b2b_cnt", n_rdy0, 4);
        chk("b2b_w1", w0[1], 8'h00);
        chk("b2b_w2", w0[2], 8'hFF);
        chk("b2b_w3", w0[3], 8'h3C);

        rx0 = 1'b0;
        hold(4);
        rx0 = 1'b1;
        hold(20);
        chk("glitch_busy", busy0, 0);
        chk("glitch_cnt", n_rdy0, 4);
        chk("glitch_errs", n_pe0 + n_fe0, 0);
        frame0(8'h5A, 1'b1);
        hold(20);
        chk("after_glitch_cnt", n_rdy0, 5);
        chk("after_glitch_word", w0[4], 8'h5A);

        frame0(8'h55, 1'b0);
        hold(39 * CPB);
        chk("break_fe", n_fe0, 1);
        chk("break_busy", busy0, 1);
        chk("break_rxdata", data0, 8'h5A);
        chk("break_cnt", n_rdy0, 5);
        rx0 = 1'b1;
        hold(10);
        chk("break_exit_busy", busy0, 0);
        frame0(8'h81, 1'b1);
        hold(20);
        chk("after_break_cnt", n_rdy0, 6);
        chk("after_break_word", w0[5], 8'h81);
        chk("after_break_fe", n_fe0, 1);

        frame1(8'h03, 1'b1);
        hold(20);
        chk("par_bad_pe", n_pe1, 1);
        chk("par_bad_rdy", n_rdy1, 0);
        chk("par_bad_rxdata", data1, 8'h00);
        frame1(8'h03, 1'b0);
        hold(20);
        chk("par_ok_rdy", n_rdy1, 1);
        chk("par_ok_rxdata", data1, 8'h03);
        frame1(8'h07, 1'b1);
        hold(20);
        chk("par_odd_rdy", n_rdy1, 2);
        chk("par_odd_rxdata", data1, 8'h07);
        chk("par_errs", {n_pe1[15:0], n_fe1[15:0]}, 32'h0001_0000);

        d = 8'h96;
        bit0(1'b0);
        for (int i = 0; i < 4; i++) bit0(d[i]);
        rx0 = d[4];
        hold(8);
        chk("mid_frame_busy", busy0, 1);
        rst = 1'b1;
        hold(2);
        chk("rst_mid_u0", {data0, rdy0, perr0, ferr0, busy0}, 0);
        chk("rst_mid_u1", data1, 8'h00);
        hold(6);
        for (int i = 5; i < 8; i++) bit0(d[i]);
        bit0(1'b1);
        hold(4);
        rst = 1'b0;
        hold(20);
        chk("rst_no_strobe", n_rdy0 + n_pe0 + n_fe0, 7);

        bist = 1'b1;
        hold(2);
        rx0 = 1'b0;
        hold(CPB);
        chk("bist_busy", busy0, 0);
        d = 8'h42;
        for (int i = 0; i < 8; i++) bit0(d[i]);
        bit0(1'b1);
        hold(20);
        chk("bist_no_strobe", n_rdy0 + n_pe0 + n_fe0, 7);
        chk("bist_rxdata", data0, 8'h00);
        bist = 1'b0;
        hold(5);
        frame0(8'h42, 1'b1);
        hold(20);
        chk("post_bist_cnt", n_rdy0, 7);
        chk("post_bist_word", w0[6], 8'h42);
        chk("post_bist_rxdata", data0, 8'h42);
        chk("no_overlap", n_multi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that sits directly upstream of the receive FIFO. Oversamples the asynchronous `Rx` line and reassembles start/data/parity/stop frames into parallel words. Delivers each good word as `Rx_Data` with a one-cycle `Data_Rdy` strobe, which connects straight to the FIFO write side. Reports parity and framing errors as one-cycle pulses and drops the errored word.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; also the `Rx_Data` width.
- `CLKS_PER_BIT`, 868: clock cycles per bit period. Must be even and ≥ 4.
- `PARITY_EN`, 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN`=0.

Ports:
- `clk` in, 1: single clock for the whole block.
- `rst` in, 1: synchronous, active-high reset.
- `Rx` in, 1: asynchronous serial line, idles high.
- `BIST_Mode` in, 1: when high, the receiver is held idle and ignores `Rx`.
- `Rx_Data` out, DATA_BITS: last good received word.
- `Data_Rdy` out, 1: one-cycle strobe; `Rx_Data` is valid in the same cycle.
- `Parity_Err` out, 1: one-cycle pulse on a parity mismatch.
- `Framing_Err` out, 1: one-cycle pulse when the stop bit samples 0.
- `Rx_Busy` out, 1: high in every state except IDLE.

## Operation
- **Synchronizer:** `Rx` passes through a 2-flop synchronizer (reset value 1), followed by one more flop for edge detection. Call the synchronized value `rx_s`.
- **Start detect:** a start edge is `rx_s`=0 with the previous `rx_s`=1, while in IDLE and `BIST_Mode`=0.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **Counters:**
  - Bit-timer counter, 0..CLKS_PER_BIT-1.
  - Bit index, 0..DATA_BITS-1.
  - Shift register, DATA_BITS wide; bits shift in from the MSB so the LSB arrives first.
- **IDLE:** on a start edge, go to START with timer=0.
- **START:** sample when timer = CLKS_PER_BIT/2-1 (mid start bit).
  - `rx_s`=0: go to DATA, timer=0, index=0.
  - `rx_s`=1: glitch. Return to IDLE with no flags.
- **DATA:** sample when timer = CLKS_PER_BIT-1.
  - Shift in `rx_s`.
  - At index = DATA_BITS-1, go to PARITY if `PARITY_EN`, otherwise STOP.
- **PARITY:** sample at timer = CLKS_PER_BIT-1 and store `par_bad`.
  - Expected bit = XOR of the data bits, inverted when `PARITY_ODD`.
  - `par_bad` = received bit ≠ expected bit.
- **STOP:** sample at timer = CLKS_PER_BIT-1. One registered outcome follows on the next cycle:
  - `rx_s`=1 and not `par_bad`: `Rx_Data` ← shift register and `Data_Rdy`=1. Next state IDLE.
  - `rx_s`=1 and `par_bad`: `Parity_Err`=1, `Rx_Data` unchanged. Next state IDLE.
  - `rx_s`=0: `Framing_Err`=1 (takes priority over a parity error), `Rx_Data` unchanged. Next state WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `Framing_Err`.
- **Early return:** the receiver returns to IDLE at mid stop bit, so a new start edge is accepted immediately.
- **BIST_Mode:**
  - Asserted in any state: the next state is IDLE and the timer is cleared.
  - No strobes are produced, and `Rx_Data` holds its value.
  - On deassertion, a start edge is only accepted from a fresh 1→0 transition of `rx_s`.
- **Reset:** `rst` takes priority over everything, including mid-frame. A partial frame is discarded.

## Timing
- Reset values:
  - State IDLE; timer, index and shift register all 0.
  - Synchronizer flops 1.
  - `Rx_Data`=0; `Data_Rdy`, `Parity_Err`, `Framing_Err` and `Rx_Busy` all 0.
- All outputs are registered.
- At most one of `Data_Rdy`, `Parity_Err`, `Framing_Err` is high in any cycle. Each is exactly 1 cycle wide.
- Latency:
  - The start edge is seen by the FSM 2 cycles after `Rx` falls (synchronizer).
  - Stop sample N = CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + 1)·CLKS_PER_BIT cycles after START entry.
  - The strobe follows the stop sample by 1 cycle.
- `Rx_Busy` rises the cycle after the start edge. It falls in the strobe cycle, or when WAIT_HIGH exits.
- The downstream FIFO never back-pressures this block; a word sent to a full FIFO is lost in the FIFO.

## Test plan
Directed tests use `CLKS_PER_BIT`=16.
- **Good frame:** frame 0xA5, 8N1 → one `Data_Rdy` pulse with `Rx_Data`=0xA5, no error pulses, `Rx_Busy` low afterwards. Strobe arrives 2+1+8+16·9+1 cycles after `Rx` falls, ±1.
- **Back-to-back:** frames 0x00, 0xFF, 0x3C with a 1-bit stop and no idle gap → three `Data_Rdy` pulses carrying those values in order.
- **Glitch rejection:** `Rx` low for 4 cycles, then high → no strobes, state returns to IDLE. A valid frame 0x5A that follows is received correctly.
- **Parity:** `PARITY_EN`=1, even parity, data 0x03.
  - Parity bit 1 → `Parity_Err` pulse, no `Data_Rdy`, `Rx_Data` unchanged.
  - Parity bit 0 → `Rx_Data`=0x03.
- **Framing/break:** stop bit 0, then `Rx` held low for 40 bit times → exactly one `Framing_Err`, `Rx_Busy` held high until `Rx` rises. The next frame 0x81 is then received correctly.
- **Reset and BIST:**
  - `rst` asserted during data bit 4 → outputs return to reset values, and no strobe arrives for the aborted frame.
  - A frame sent with `BIST_Mode`=1 → no strobes.
  - A frame sent after `BIST_Mode` deasserts → received normally.
